// File: rtl/reg_write_queue.sv
// Ordered write-back buffer in front of the register file write port.
// Drains one entry per cycle and forwards the youngest pending value for two lookups.
module reg_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] in_reg_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          drain_en_i,
    output logic          rf_write_o,
    output logic [AW-1:0] rf_wr_o,
    output logic [DW-1:0] rf_wd_o,
    input  logic [AW-1:0] q_rr1_i,
    input  logic [AW-1:0] q_rr2_i,
    output logic          fwd1_hit_o,
    output logic          fwd2_hit_o,
    output logic [DW-1:0] fwd1_data_o,
    output logic [DW-1:0] fwd2_data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [AW-1:0] ent_reg_q  [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [PW-1:0] idx;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign rf_write_o = !empty_o && drain_en_i && !flush_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready_o = !full_o || rf_write_o;
    assign rf_wr_o    = empty_o ? '0 : ent_reg_q[head_q];
    assign rf_wd_o    = empty_o ? '0 : ent_data_q[head_q];

    // Writes to register 0 are accepted but never stored.
    assign push = in_valid_i && in_ready_o && (in_reg_i != '0) && !flush_i;
    assign pop  = rf_write_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                ent_reg_q[tail_q]  <= in_reg_i;
                ent_data_q[tail_q] <= in_data_i;
            end
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd2_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_data_o = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (q_rr1_i != '0 && ent_reg_q[idx] == q_rr1_i) begin
                    fwd1_hit_o  = 1'b1;
                    fwd1_data_o = ent_data_q[idx];
                end
                if (q_rr2_i != '0 && ent_reg_q[idx] == q_rr2_i) begin
                    fwd2_hit_o  = 1'b1;
                    fwd2_data_o = ent_data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench: accepted writes are queued as expected drains; a monitor
// compares each register-file write and models the falling-edge register file.
module tb_reg_write_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, drain_en, rf_write;
    logic [AW-1:0] in_reg, rf_wr, q_rr1, q_rr2;
    logic [DW-1:0] in_data, rf_wd, fwd1_data, fwd2_data;
    logic          fwd1_hit, fwd2_hit, empty, full;
    logic [CW-1:0] count;

    typedef struct packed { logic [AW-1:0] r; logic [DW-1:0] d; } wr_t;
    wr_t           exp_q[$];
    logic [DW-1:0] rf [4];
    int            n_pass = 0, n_total = 0;
    logic [DW-1:0] saved;

    always #5 clk = ~clk;

    reg_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clock_i(clk), .reset_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_reg_i(in_reg), .in_data_i(in_data),
        .drain_en_i(drain_en), .rf_write_o(rf_write), .rf_wr_o(rf_wr), .rf_wd_o(rf_wd),
        .q_rr1_i(q_rr1), .q_rr2_i(q_rr2),
        .fwd1_hit_o(fwd1_hit), .fwd2_hit_o(fwd2_hit),
        .fwd1_data_o(fwd1_data), .fwd2_data_o(fwd2_data),
        .count_o(count), .empty_o(empty), .full_o(full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Register file model plus drain monitor, both on the falling edge.
    always @(negedge clk) begin
        if (rf_write) begin
            rf[rf_wr] <= rf_wd;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL drain_unexpected: got r%0d=0x%0h expected no write", rf_wr, rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_wr === e.r && rf_wd === e.d) n_pass++;
                else $display("FAIL drain_order: got r%0d=0x%0h expected r%0d=0x%0h",
                              rf_wr, rf_wd, e.r, e.d);
            end
        end
    end

    // One cycle of stimulus; records the expected drain when the push lands.
    task automatic cyc(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        logic acc;
        in_valid = v; in_reg = r; in_data = d;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (flush) exp_q.delete();
        else if (acc && r != '0) exp_q.push_back('{r: r, d: d});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
        drain_en = 1'b1; q_rr1 = '0; q_rr2 = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_rf_wr_wd", {rf_wr, rf_wd}, 0);
        q_rr1 = 2'd1; q_rr2 = 2'd2; #1;
        chk("rst_fwd", {fwd1_hit, fwd2_hit, fwd1_data, fwd2_data}, 0);
        q_rr1 = '0; q_rr2 = '0;
        @(posedge clk); rst = 1'b0; #1;

        // back-to-back pushes drained in order with one-cycle latency
        cyc(1'b1, 2'd1, 16'h1111);
        chk("lat_rf_write", rf_write, 1);
        chk("lat_rf_head", {rf_wr, rf_wd}, {2'd1, 16'h1111});
        cyc(1'b1, 2'd2, 16'h2222);
        cyc(1'b1, 2'd3, 16'h3333);
        idle(3);
        chk("rf_r1", rf[1], 16'h1111);
        chk("rf_r2", rf[2], 16'h2222);
        chk("rf_r3", rf[3], 16'h3333);
        chk("t1_empty", empty, 1);

        // forwarding: youngest of two writes to r2 wins, r0 never hits
        drain_en = 1'b0;
        cyc(1'b1, 2'd2, 16'hAAAA);
        cyc(1'b1, 2'd2, 16'hBBBB);
        in_valid = 1'b0; q_rr1 = 2'd2; q_rr2 = 2'd0; #1;
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_data", fwd1_data, 16'hBBBB);
        chk("fwd2_r0", {fwd2_hit, fwd2_data}, 0);
        chk("t2_count", count, 2);
        q_rr2 = 2'd3; #1;
        chk("fwd2_miss", {fwd2_hit, fwd2_data}, 0);
        drain_en = 1'b1; #1;
        chk("fwd_while_drain", {rf_write, fwd1_hit, fwd1_data}, {2'b11, 16'hBBBB});
        idle(3);
        q_rr1 = '0; q_rr2 = '0;

        // fill to full, then push+pop together across the pointer wrap
        drain_en = 1'b0;
        cyc(1'b1, 2'd1, 16'hC001);
        cyc(1'b1, 2'd2, 16'hC002);
        cyc(1'b1, 2'd3, 16'hC003);
        cyc(1'b1, 2'd1, 16'hC004);
        in_valid = 1'b1; in_reg = 2'd2; in_data = 16'hD005; #1;
        chk("full_flag", full, 1);
        chk("full_not_ready", in_ready, 0);
        drain_en = 1'b1; #1;
        chk("full_ready_on_pop", in_ready, 1);
        cyc(1'b1, 2'd2, 16'hD005);
        chk("full_count_hold", count, DEPTH);
        q_rr1 = 2'd1; #1;
        chk("wrap_fwd_youngest", {fwd1_hit, fwd1_data}, {1'b1, 16'hC004});
        q_rr1 = '0;
        idle(6);
        chk("t3_empty", empty, 1);

        // register 0 writes are accepted and dropped
        drain_en = 1'b0;
        in_valid = 1'b1; in_reg = 2'd0; in_data = 16'h5555; #1;
        chk("r0_ready", in_ready, 1);
        cyc(1'b1, 2'd0, 16'h5555);
        chk("r0_count", count, 0);
        drain_en = 1'b1;
        idle(2);

        // flush discards the queue and the concurrent push
        drain_en = 1'b0;
        cyc(1'b1, 2'd1, 16'hE001);
        cyc(1'b1, 2'd2, 16'hE002);
        cyc(1'b1, 2'd3, 16'hE003);
        flush = 1'b1; drain_en = 1'b1;
        cyc(1'b1, 2'd3, 16'hE004);
        flush = 1'b0; in_valid = 1'b0; q_rr1 = 2'd3; q_rr2 = 2'd1; #1;
        chk("flush_count", count, 0);
        chk("flush_rf_write", rf_write, 0);
        chk("flush_fwd", {fwd1_hit, fwd2_hit, fwd1_data, fwd2_data}, 0);
        q_rr1 = '0; q_rr2 = '0;
        idle(2);

        // asynchronous reset while a drain is on the port
        drain_en = 1'b0;
        cyc(1'b1, 2'd1, 16'h7777);
        cyc(1'b1, 2'd2, 16'h8888);
        in_valid = 1'b0;
        saved = rf[1];
        drain_en = 1'b1; #1;
        chk("pre_rst_rf_write", rf_write, 1);
        rst = 1'b1; exp_q.delete(); #1;
        chk("async_rst_rf_write", rf_write, 0);
        chk("async_rst_count", count, 0);
        @(negedge clk); #1;
        chk("async_rst_rf_kept", rf[1], saved);
        @(posedge clk); rst = 1'b0; #1;
        idle(2);
        chk("end_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Write-back buffer that sits between the execute/memory stages and the 4×16 register file's write port. Producers push (register, data) write requests through a valid/ready handshake; the block stores up to DEPTH of them in order and drains one per cycle onto the register file's RegWrite/WR/WD port, which commits on the falling clock edge. While writes are pending, the block forwards the youngest queued value for up to two read addresses, so decode never reads stale register contents.

## Interface
- DEPTH, 4: queue entries; a power of two, at least 2.
- DW, 16: data width.
- AW, 2: register address width.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; discards every queued entry.
- in_valid  in  1  a write request is presented.
- in_ready  out  1  the block can accept the request this cycle.
- in_reg  in  AW  destination register.
- in_data  in  DW  write data.
- drain_en  in  1  permits draining to the register file this cycle.
- rf_write  out  1  drives the register file RegWrite input.
- rf_wr  out  AW  drives the register file WR input.
- rf_wd  out  DW  drives the register file WD input.
- q_rr1, q_rr2  in  AW  forwarding lookup addresses; the same values as the register file RR1/RR2.
- fwd1_hit, fwd2_hit  out  1  a pending write matches the lookup address.
- fwd1_data, fwd2_data  out  DW  youngest pending data for that address; 0 when there is no hit.
- count  out  log2(DEPTH)+1  number of valid entries.
- empty, full  out  1  count==0, count==DEPTH.

## Operation
- Circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH; count is tracked separately.
- Push happens when in_valid && in_ready.
  - If in_reg==0, the request is accepted and dropped: no entry is written and count is unchanged. Register 0 is hardwired to zero.
- in_ready = !full || rf_write.
  - When the queue is full, a push is accepted in the same cycle as a pop.
- rf_write = !empty && drain_en && !flush.
- rf_wr and rf_wd equal the head entry when !empty, and 0 otherwise.
- Pop happens at the rising edge that ends any cycle in which rf_write=1.
  - The register file has already committed that entry on the falling edge inside the cycle.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- flush has priority over push and pop. At the next edge, count=0 and head=tail=0, and the push in that cycle is discarded.
- Forwarding is purely combinational over valid entries only.
  - On multiple matches, the youngest entry (closest to tail) wins.
  - A lookup address of 0 never hits.
  - An entry remains forwardable during the cycle in which it is drained.
  - The request currently on in_* is not forwarded.

## Timing
- Reset values: count=0, empty=1, full=0, in_ready=1, rf_write=0, rf_wr=0, rf_wd=0, fwd*_hit=0, fwd*_data=0, both pointers=0.
- Latency from push to rf_write: 1 cycle minimum. An entry pushed at edge N appears on rf_* during cycle N+1, provided it is at the head and drain_en=1.
- Throughput: 1 push and 1 drain per cycle sustained.
- Combinational paths:
  - drain_en → rf_write → in_ready.
  - q_rr* → fwd*.
  - No path from in_valid to in_ready.
- Reset asserted mid-operation clears the queue immediately. rf_write drops asynchronously, so no register file write happens on the following falling edge.
- drain_en=0 holds the head stable and rf_write=0. The queue fills, and in_ready falls when count==DEPTH.
- Pointer wrap (DEPTH-1 → 0) has no effect on ordering or forwarding priority.

## Test plan
- Reset, then push (r1,0x1111), (r2,0x2222), (r3,0x3333) on back-to-back cycles with drain_en=1 → rf_* shows r1, r2, r3 on consecutive cycles starting 1 cycle after the first push; the register file reads 0x1111/0x2222/0x3333; empty=1 afterwards.
- drain_en=0; push (r2,0xAAAA) then (r2,0xBBBB); q_rr1=2, q_rr2=0 → fwd1_hit=1, fwd1_data=0xBBBB; fwd2_hit=0; count=2.
- drain_en=0; push DEPTH entries → full=1, in_ready=0. Raise drain_en with in_valid held → in_ready=1, count stays DEPTH for that cycle, FIFO order is preserved across the pointer wrap.
- Push (r0,0x5555) → in_ready=1, count unchanged, rf_write never asserts for r0.
- Queue 3 entries, then assert flush with in_valid=1 → next cycle count=0, rf_write=0, no pending data forwarded.
- Assert reset asynchronously while rf_write=1 → rf_write=0 before the falling edge, and the register file contents are unchanged.
